spi_reg_ctrl: RTL and testbench

Command/register controller between the SPI slave byte interface and the RGB LED driver on the iCE40UP5K. It decodes framed SPI byte streams into register reads and writes, holds the LED configuration registers, and supplies MISO reply bytes. It generates three 8-bit PWM signals feeding `SB_RGBA_DRV` RGB0PWM/RGB1PWM/RGB2PWM, CURREN and RGBLEDEN.

---
 rtl/spi_led_pkg.sv | 24 ++
 rtl/rgb_pwm.sv | 41 ++++
 rtl/spi_reg_ctrl.sv | 169 ++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_led_pkg.sv
// Shared definitions for the SPI register controller and its RGB PWM driver.
// Contents: command byte codes, register addresses and the frame FSM state enum.
package spi_led_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  localparam logic [2:0] REG_DUTY_R = 3'd0;
  localparam logic [2:0] REG_DUTY_G = 3'd1;
  localparam logic [2:0] REG_DUTY_B = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_ID     = 3'd4;
  localparam logic [2:0] REG_ERR    = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StWrite,
    StRead,
    StDiscard
  } state_e;

endpackage

// File: rtl/rgb_pwm.sv
// Three-channel 8-bit PWM generator sharing one free-running counter.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   duty_r, duty_g, duty_b   live duty values (0 = off, 255 = 255/256 on)
//   en                       global enable; forces all outputs low when 0
//   pwm_r, pwm_g, pwm_b      registered PWM outputs
module rgb_pwm (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] duty_r,
  input  logic [7:0] duty_g,
  input  logic [7:0] duty_b,
  input  logic       en,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b
);

  logic [7:0] cnt_q;
  logic       pwm_r_q, pwm_g_q, pwm_b_q;

  // Compare is against the live duty registers: updates apply mid-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 8'h00;
      pwm_r_q <= 1'b0;
      pwm_g_q <= 1'b0;
      pwm_b_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + 8'd1;
      pwm_r_q <= en & (cnt_q < duty_r);
      pwm_g_q <= en & (cnt_q < duty_g);
      pwm_b_q <= en & (cnt_q < duty_b);
    end
  end

  assign pwm_r = pwm_r_q;
  assign pwm_g = pwm_g_q;
  assign pwm_b = pwm_b_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command/register controller for the RGB LED driver.
// Frame: command byte, address byte, then data bytes with auto-incrementing address.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   ss_active          frame active (synchronised)
//   rx_valid, rx_data  received MOSI byte strobe and data
//   tx_data            next MISO byte
//   pwm_r/g/b          PWM outputs to RGB0PWM/RGB1PWM/RGB2PWM
//   led_en, curren     to RGBLEDEN and CURREN
module spi_reg_ctrl
  import spi_led_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic       led_en,
  output logic       curren
);

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] duty_r_q, duty_r_d;
  logic [7:0] duty_g_q, duty_g_d;
  logic [7:0] duty_b_q, duty_b_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [7:0] err_q, err_d;
  logic       armed_q, armed_d;

  logic [2:0] rd_addr;
  logic [7:0] rd_data;

  // The address byte itself selects the first read location.
  assign rd_addr = (state_q == StAddr) ? rx_data[2:0] : addr_q;

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      REG_DUTY_R: rd_data = duty_r_q;
      REG_DUTY_G: rd_data = duty_g_q;
      REG_DUTY_B: rd_data = duty_b_q;
      REG_CTRL:   rd_data = {6'b0, ctrl_q};
      REG_ID:     rd_data = ID_VALUE;
      REG_ERR:    rd_data = err_q;
      default:    rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    tx_d     = tx_q;
    duty_r_d = duty_r_q;
    duty_g_d = duty_g_q;
    duty_b_d = duty_b_q;
    ctrl_d   = ctrl_q;
    err_d    = err_q;
    // After reset, a frame only starts once SS has been seen idle.
    armed_d  = armed_q | ((state_q == StIdle) & ~ss_active);

    if (!ss_active) begin
      // SS fall wins over a coincident rx_valid.
      state_d = StIdle;
      tx_d    = 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (armed_q) state_d = StCmd;
        end
        StCmd: begin
          if (rx_valid) begin
            cmd_d   = rx_data;
            state_d = StAddr;
            if (rx_data != CMD_WRITE && rx_data != CMD_READ && err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end
          end
        end
        StAddr: begin
          if (rx_valid) begin
            if (cmd_q == CMD_WRITE) begin
              state_d = StWrite;
              addr_d  = rx_data[2:0];
            end else if (cmd_q == CMD_READ) begin
              state_d = StRead;
              tx_d    = rd_data;
              addr_d  = rx_data[2:0] + 3'd1;
            end else begin
              state_d = StDiscard;
            end
          end
        end
        StWrite: begin
          if (rx_valid) begin
            case (addr_q)
              REG_DUTY_R: duty_r_d = rx_data;
              REG_DUTY_G: duty_g_d = rx_data;
              REG_DUTY_B: duty_b_d = rx_data;
              REG_CTRL:   ctrl_d   = rx_data[1:0];
              default:    ;
            endcase
            addr_d = addr_q + 3'd1;
          end
        end
        StRead: begin
          if (rx_valid) begin
            tx_d   = rd_data;
            addr_d = addr_q + 3'd1;
          end
        end
        StDiscard: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cmd_q    <= 8'h00;
      addr_q   <= 3'd0;
      tx_q     <= 8'h00;
      duty_r_q <= 8'h00;
      duty_g_q <= 8'h00;
      duty_b_q <= 8'h00;
      ctrl_q   <= 2'b00;
      err_q    <= 8'h00;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      tx_q     <= tx_d;
      duty_r_q <= duty_r_d;
      duty_g_q <= duty_g_d;
      duty_b_q <= duty_b_d;
      ctrl_q   <= ctrl_d;
      err_q    <= err_d;
      armed_q  <= armed_d;
    end
  end

  assign tx_data = tx_q;
  assign led_en  = ctrl_q[0];
  assign curren  = ctrl_q[1];

  rgb_pwm u_rgb_pwm (
    .clk    (clk),
    .rst    (rst),
    .duty_r (duty_r_q),
    .duty_g (duty_g_q),
    .duty_b (duty_b_q),
    .en     (ctrl_q[0]),
    .pwm_r  (pwm_r),
    .pwm_g  (pwm_g),
    .pwm_b  (pwm_b)
  );

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: byte-level frame vectors plus
// hand-written sequences for PWM, error counting, frame aborts and reset.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       pwm_r, pwm_g, pwm_b;
  logic       led_en, curren;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_reg_ctrl #(.ID_VALUE(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .ss_active (ss_active),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .pwm_r     (pwm_r),
    .pwm_g     (pwm_g),
    .pwm_b     (pwm_b),
    .led_en    (led_en),
    .curren    (curren)
  );

  typedef struct packed {
    logic       start;  // begin a new frame before this byte
    logic [7:0] data;
    logic [7:0] exp_tx; // tx_data expected after this byte
  } vec_t;

  localparam int N = 37;
  vec_t vecs [N];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_end();
    ss_active = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame_begin();
    ss_active = 1'b1;
    repeat (3) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic read_reg(input string name, input logic [2:0] a, input logic [7:0] exp);
    frame_end();
    frame_begin();
    send_byte(8'h02);
    send_byte({5'b0, a});
    check(name, tx_data, exp);
    frame_end();
  endtask

  int cnt_r, cnt_g, cnt_b;

  initial begin
    vecs = '{
      // write duties and ctrl
      '{1'b1, 8'h01, 8'h00}, '{1'b0, 8'h00, 8'h00}, '{1'b0, 8'h80, 8'h00},
      '{1'b0, 8'h40, 8'h00}, '{1'b0, 8'hFF, 8'h00}, '{1'b0, 8'h03, 8'h00},
      // read 3,4,5
      '{1'b1, 8'h02, 8'h00}, '{1'b0, 8'h03, 8'h03}, '{1'b0, 8'h00, 8'hA5},
      '{1'b0, 8'h00, 8'h00},
      // read 7 then wrap to 0
      '{1'b1, 8'h02, 8'h00}, '{1'b0, 8'h07, 8'h00}, '{1'b0, 8'h00, 8'h80},
      // read 0..3; address bits [7:3] ignored
      '{1'b1, 8'h02, 8'h00}, '{1'b0, 8'hF8, 8'h80}, '{1'b0, 8'h00, 8'h40},
      '{1'b0, 8'h00, 8'hFF}, '{1'b0, 8'h00, 8'h03},
      // writes to 4..7 are dropped
      '{1'b1, 8'h01, 8'h00}, '{1'b0, 8'h04, 8'h00}, '{1'b0, 8'h12, 8'h00},
      '{1'b0, 8'h34, 8'h00}, '{1'b0, 8'h56, 8'h00}, '{1'b0, 8'h78, 8'h00},
      '{1'b1, 8'h02, 8'h00}, '{1'b0, 8'h04, 8'hA5}, '{1'b0, 8'h00, 8'h00},
      '{1'b0, 8'h00, 8'h00}, '{1'b0, 8'h00, 8'h00},
      // ctrl upper bits masked, then restore 0x03
      '{1'b1, 8'h01, 8'h00}, '{1'b0, 8'h03, 8'h00}, '{1'b0, 8'hFE, 8'h00},
      '{1'b1, 8'h02, 8'h00}, '{1'b0, 8'h03, 8'h02},
      '{1'b1, 8'h01, 8'h00}, '{1'b0, 8'h03, 8'h00}, '{1'b0, 8'h03, 8'h00}
    };

    rst       = 1'b1;
    ss_active = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset tx_data", tx_data, 8'h00);
    check("reset led_en", {7'b0, led_en}, 8'h00);
    check("reset curren", {7'b0, curren}, 8'h00);
    check("reset pwm", {5'b0, pwm_r, pwm_g, pwm_b}, 8'h00);

    for (int i = 0; i < N; i++) begin
      if (vecs[i].start) begin
        frame_end();
        frame_begin();
      end
      send_byte(vecs[i].data);
      check($sformatf("vec%0d tx", i), tx_data, vecs[i].exp_tx);
    end
    frame_end();
    check("tx idle", tx_data, 8'h00);

    // PWM duty cycles over one full period
    check("led_en on", {7'b0, led_en}, 8'h01);
    check("curren on", {7'b0, curren}, 8'h01);
    cnt_r = 0; cnt_g = 0; cnt_b = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      cnt_r += int'(pwm_r);
      cnt_g += int'(pwm_g);
      cnt_b += int'(pwm_b);
    end
    check("pwm_r high count", 8'(cnt_r), 8'd128);
    check("pwm_g high count", 8'(cnt_g), 8'd64);
    check("pwm_b high count", 8'(cnt_b), 8'd255);

    // Bad command: discarded, err_cnt counts once per frame
    frame_begin();
    send_byte(8'h7E);
    send_byte(8'h00);
    send_byte(8'h55);
    read_reg("err after 1 bad", 3'd5, 8'h01);
    read_reg("duty_r after bad", 3'd0, 8'h80);
    for (int i = 0; i < 299; i++) begin
      frame_begin();
      send_byte(8'h7E);
      send_byte(8'h00);
      send_byte(8'h55);
      frame_end();
    end
    read_reg("err saturated", 3'd5, 8'hFF);

    // Frame ends after the address byte: no write to duty_b
    frame_begin();
    send_byte(8'h01);
    send_byte(8'h02);
    read_reg("duty_b after short", 3'd2, 8'hFF);

    // Byte coincident with SS fall is dropped
    frame_begin();
    send_byte(8'h01);
    send_byte(8'h00);
    rx_data   = 8'h11;
    rx_valid  = 1'b1;
    ss_active = 1'b0;
    tick();
    rx_valid = 1'b0;
    read_reg("duty_r after drop", 3'd0, 8'h80);

    // Write visible one cycle after rx_valid, then reset mid-WRITE
    frame_begin();
    send_byte(8'h01);
    send_byte(8'h03);
    rx_data  = 8'h01;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("ctrl write led_en", {7'b0, led_en}, 8'h01);
    check("ctrl write curren", {7'b0, curren}, 8'h00);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst led_en", {7'b0, led_en}, 8'h00);
    check("rst pwm", {5'b0, pwm_r, pwm_g, pwm_b}, 8'h00);
    check("rst tx", tx_data, 8'h00);
    // SS still high: these bytes must be ignored
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h03);
    check("ignored led_en", {7'b0, led_en}, 8'h00);
    check("ignored curren", {7'b0, curren}, 8'h00);
    read_reg("duty_r after rst", 3'd0, 8'h00);
    read_reg("ctrl after rst", 3'd3, 8'h00);
    read_reg("id after rst", 3'd4, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
